// File: rtl/alu_op_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer_pkg
//
// Shared definitions for the ALU operation sequencer and the ALU it drives:
//   - opcode field geometry and opcode constants (instruction bits [31:27])
//   - wait-counter width
//   - sequencer state encoding (2-bit)
//   - helper to extract the opcode from an instruction word
// ---------------------------------------------------------------------------
package alu_op_sequencer_pkg;

  localparam int unsigned OPC_W  = 5;
  localparam int unsigned IR_W   = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 8;

  // Opcode map. Codes 01101, 01110 and 10100-11111 are unassigned.
  localparam logic [OPC_W-1:0] OP_LD     = 5'b00000;
  localparam logic [OPC_W-1:0] OP_LDI    = 5'b00001;
  localparam logic [OPC_W-1:0] OP_ST     = 5'b00010;
  localparam logic [OPC_W-1:0] OP_ADD    = 5'b00011;
  localparam logic [OPC_W-1:0] OP_SUB    = 5'b00100;
  localparam logic [OPC_W-1:0] OP_AND    = 5'b00101;
  localparam logic [OPC_W-1:0] OP_OR     = 5'b00110;
  localparam logic [OPC_W-1:0] OP_ROR    = 5'b00111;
  localparam logic [OPC_W-1:0] OP_ROL    = 5'b01000;
  localparam logic [OPC_W-1:0] OP_SHR    = 5'b01001;
  localparam logic [OPC_W-1:0] OP_SHRA   = 5'b01010;
  localparam logic [OPC_W-1:0] OP_SHL    = 5'b01011;
  localparam logic [OPC_W-1:0] OP_ADDI   = 5'b01100;
  localparam logic [OPC_W-1:0] OP_MUL    = 5'b01111;
  localparam logic [OPC_W-1:0] OP_DIV    = 5'b10000;
  localparam logic [OPC_W-1:0] OP_NEG    = 5'b10001;
  localparam logic [OPC_W-1:0] OP_NOT    = 5'b10010;
  localparam logic [OPC_W-1:0] OP_BRANCH = 5'b10011;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_EXEC = 2'b10,
    ST_RESP = 2'b11
  } seq_state_e;

  // Opcode field of an instruction word.
  function automatic logic [OPC_W-1:0] ir_opcode(input logic [IR_W-1:0] ir);
    return ir[IR_W-1 -: OPC_W];
  endfunction

endpackage : alu_op_sequencer_pkg

// File: rtl/alu_op_sequencer_op_decode.sv
// ---------------------------------------------------------------------------
// op_decode
//
// Pure combinational opcode classifier for the sequencer.
//   opcode      : in  - instruction opcode field
//   legal       : out - opcode is assigned
//   is_wide     : out - result uses both zlow and zhigh (multiply / divide)
//   wait_cycles : out - extra EXEC cycles beyond the first one
// ---------------------------------------------------------------------------
module op_decode
  import alu_op_sequencer_pkg::*;
#(
  parameter int unsigned MUL_WAIT = 2,
  parameter int unsigned DIV_WAIT = 4
) (
  input  logic [OPC_W-1:0] opcode,
  output logic             legal,
  output logic             is_wide,
  output logic [CNT_W-1:0] wait_cycles
);

  localparam logic [CNT_W-1:0] MUL_WAIT_C = CNT_W'(MUL_WAIT);
  localparam logic [CNT_W-1:0] DIV_WAIT_C = CNT_W'(DIV_WAIT);

  // Classify opcode: legality, wide result and extra execute cycles.
  always_comb begin
    legal       = 1'b0;
    is_wide     = 1'b0;
    wait_cycles = {CNT_W{1'b0}};
    case (opcode)
      OP_MUL: begin
        legal       = 1'b1;
        is_wide     = 1'b1;
        wait_cycles = MUL_WAIT_C;
      end
      OP_DIV: begin
        legal       = 1'b1;
        is_wide     = 1'b1;
        wait_cycles = DIV_WAIT_C;
      end
      OP_NEG, OP_NOT, OP_BRANCH: begin
        legal = 1'b1;
      end
      default: begin
        // The contiguous block 00000..01100 is legal; everything else
        // not listed above is unassigned.
        legal = (opcode <= OP_ADDI);
      end
    endcase
  end

endmodule : op_decode

// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
//
// Accepts one ALU request at a time, presents the latched instruction and
// operands to an external ALU for the required number of cycles, captures
// the ALU result and returns it through a valid/ready response channel.
//
// Ports
//   clock        : in  - rising-edge clock
//   clear        : in  - asynchronous active-low reset
//   req_valid    : in  - request present
//   req_ready    : out - sequencer idle; request taken when both high
//   req_ir       : in  - instruction, opcode in [31:27]
//   req_a/req_b  : in  - operands
//   req_flag     : in  - branch condition
//   alu_*        : out - instruction/operands/flag towards the ALU
//   alu_zlow/hi  : in  - ALU result words
//   rsp_valid    : out - response present
//   rsp_ready    : in  - response consumed when both high
//   rsp_lo/hi    : out - result words (hi meaningful when rsp_wide)
//   rsp_wide     : out - result is a multiply/divide pair
//   rsp_illegal  : out - opcode was unassigned
//   rsp_divzero  : out - divide with zero divisor
// ---------------------------------------------------------------------------
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int unsigned MUL_WAIT = 2,
  parameter int unsigned DIV_WAIT = 4
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [IR_W-1:0]   req_ir,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic              req_flag,
  output logic [IR_W-1:0]   alu_operation,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_flag,
  input  logic [DATA_W-1:0] alu_zlow,
  input  logic [DATA_W-1:0] alu_zhigh,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_lo,
  output logic [DATA_W-1:0] rsp_hi,
  output logic              rsp_wide,
  output logic              rsp_illegal,
  output logic              rsp_divzero
);

  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
  localparam logic [IR_W-1:0]   IR_ZERO   = {IR_W{1'b0}};

  seq_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // The alu_* registers double as the latched request.
  logic [IR_W-1:0]   alu_operation_q, alu_operation_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic              alu_flag_q, alu_flag_d;

  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_lo_q, rsp_lo_d;
  logic [DATA_W-1:0] rsp_hi_q, rsp_hi_d;
  logic              rsp_wide_q, rsp_wide_d;
  logic              rsp_illegal_q, rsp_illegal_d;
  logic              rsp_divzero_q, rsp_divzero_d;

  logic [OPC_W-1:0]  opcode;
  logic              dec_legal;
  logic              dec_is_wide;
  logic [CNT_W-1:0]  dec_wait;
  logic              div_by_zero;

  assign opcode      = ir_opcode(alu_operation_q);
  assign div_by_zero = (opcode == OP_DIV) && (alu_b_q == DATA_ZERO);

  op_decode #(
    .MUL_WAIT (MUL_WAIT),
    .DIV_WAIT (DIV_WAIT)
  ) u_op_decode (
    .opcode      (opcode),
    .legal       (dec_legal),
    .is_wide     (dec_is_wide),
    .wait_cycles (dec_wait)
  );

  // Next-state, wait counter, ALU drive and response capture.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    alu_operation_d = alu_operation_q;
    alu_a_d         = alu_a_q;
    alu_b_d         = alu_b_q;
    alu_flag_d      = alu_flag_q;
    rsp_lo_d        = rsp_lo_q;
    rsp_hi_d        = rsp_hi_q;
    rsp_wide_d      = rsp_wide_q;
    rsp_illegal_d   = rsp_illegal_q;
    rsp_divzero_d   = rsp_divzero_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          state_d         = ST_LOAD;
          alu_operation_d = req_ir;
          alu_a_d         = req_a;
          alu_b_d         = req_b;
          alu_flag_d      = req_flag;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_LOAD: begin
        if (!dec_legal) begin
          state_d       = ST_RESP;
          rsp_lo_d      = DATA_ZERO;
          rsp_hi_d      = DATA_ZERO;
          rsp_wide_d    = 1'b0;
          rsp_illegal_d = 1'b1;
          rsp_divzero_d = 1'b0;
        end else if (div_by_zero) begin
          state_d       = ST_RESP;
          rsp_lo_d      = DATA_ZERO;
          rsp_hi_d      = DATA_ZERO;
          rsp_wide_d    = 1'b1;
          rsp_illegal_d = 1'b0;
          rsp_divzero_d = 1'b1;
        end else begin
          state_d = ST_EXEC;
          cnt_d   = dec_wait;
        end
      end

      ST_EXEC: begin
        if (cnt_q == CNT_ZERO) begin
          state_d       = ST_RESP;
          rsp_lo_d      = alu_zlow;
          rsp_illegal_d = 1'b0;
          rsp_divzero_d = 1'b0;
          if (dec_is_wide) begin
            rsp_hi_d   = alu_zhigh;
            rsp_wide_d = 1'b1;
          end else begin
            rsp_hi_d   = DATA_ZERO;
            rsp_wide_d = 1'b0;
          end
        end else begin
          state_d = ST_EXEC;
          cnt_d   = cnt_q - CNT_ONE;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d       = ST_IDLE;
          rsp_lo_d      = DATA_ZERO;
          rsp_hi_d      = DATA_ZERO;
          rsp_wide_d    = 1'b0;
          rsp_illegal_d = 1'b0;
          rsp_divzero_d = 1'b0;
        end else begin
          state_d = ST_RESP;
        end
      end

      default: begin
        state_d       = ST_IDLE;
        cnt_d         = CNT_ZERO;
        rsp_lo_d      = DATA_ZERO;
        rsp_hi_d      = DATA_ZERO;
        rsp_wide_d    = 1'b0;
        rsp_illegal_d = 1'b0;
        rsp_divzero_d = 1'b0;
      end
    endcase

    // The ALU is only driven while LOAD/EXEC hold the request.
    if (state_d == ST_RESP || state_d == ST_IDLE) begin
      alu_operation_d = IR_ZERO;
      alu_a_d         = DATA_ZERO;
      alu_b_d         = DATA_ZERO;
      alu_flag_d      = 1'b0;
    end else begin
      alu_operation_d = alu_operation_d;
    end

    rsp_valid_d = (state_d == ST_RESP);
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q         <= ST_IDLE;
      cnt_q           <= CNT_ZERO;
      alu_operation_q <= IR_ZERO;
      alu_a_q         <= DATA_ZERO;
      alu_b_q         <= DATA_ZERO;
      alu_flag_q      <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_lo_q        <= DATA_ZERO;
      rsp_hi_q        <= DATA_ZERO;
      rsp_wide_q      <= 1'b0;
      rsp_illegal_q   <= 1'b0;
      rsp_divzero_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      alu_operation_q <= alu_operation_d;
      alu_a_q         <= alu_a_d;
      alu_b_q         <= alu_b_d;
      alu_flag_q      <= alu_flag_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_lo_q        <= rsp_lo_d;
      rsp_hi_q        <= rsp_hi_d;
      rsp_wide_q      <= rsp_wide_d;
      rsp_illegal_q   <= rsp_illegal_d;
      rsp_divzero_q   <= rsp_divzero_d;
    end
  end

  // req_ready is a direct state decode so a request can be taken on the
  // very first edge after clear is released.
  assign req_ready     = (state_q == ST_IDLE);
  assign alu_operation = alu_operation_q;
  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign alu_flag      = alu_flag_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_lo        = rsp_lo_q;
  assign rsp_hi        = rsp_hi_q;
  assign rsp_wide      = rsp_wide_q;
  assign rsp_illegal   = rsp_illegal_q;
  assign rsp_divzero   = rsp_divzero_q;

endmodule : alu_op_sequencer

// File: tb/tb_alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_op_sequencer
//
// Directed and random requests against a reference model; expected
// responses queue up at accept time and a monitor compares them (contents,
// latency, stability while stalled) whenever rsp_valid is seen.
// ---------------------------------------------------------------------------
module tb_alu_op_sequencer;

  localparam int MUL_W = 2;
  localparam int DIV_W = 4;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_ir = 32'd0;
  logic [31:0] req_a = 32'd0;
  logic [31:0] req_b = 32'd0;
  logic        req_flag = 1'b0;
  logic [31:0] alu_operation, alu_a, alu_b;
  logic        alu_flag;
  logic [31:0] alu_zlow, alu_zhigh;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_lo, rsp_hi;
  logic        rsp_wide, rsp_illegal, rsp_divzero;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hold_cnt = 0;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        wide;
    logic        ill;
    logic        dz;
    int          lat;
    int          acc;
  } exp_t;

  exp_t expq[$];
  exp_t cur;
  bit   have_cur = 1'b0;

  alu_op_sequencer #(.MUL_WAIT(MUL_W), .DIV_WAIT(DIV_W)) dut (
    .clock(clock), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_ir(req_ir), .req_a(req_a), .req_b(req_b), .req_flag(req_flag),
    .alu_operation(alu_operation), .alu_a(alu_a), .alu_b(alu_b), .alu_flag(alu_flag),
    .alu_zlow(alu_zlow), .alu_zhigh(alu_zhigh),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_lo(rsp_lo), .rsp_hi(rsp_hi), .rsp_wide(rsp_wide),
    .rsp_illegal(rsp_illegal), .rsp_divzero(rsp_divzero)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Simple ALU: {hi, lo} result for an opcode; hi is deliberately nonzero
  // for narrow ops so a leaked hi word is visible.
  function automatic logic [63:0] alu_model(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic flag);
    logic [63:0] r;
    case (op)
      5'd3:  r = {~a, a + b};
      5'd4:  r = {~a, a - b};
      5'd15: r = {32'd0, a} * {32'd0, b};
      5'd16: r = (b == 32'd0) ? 64'd0 : {a % b, a / b};
      5'd19: r = {~a, flag ? a + b : a};
      default: r = {~b, a ^ b ^ {27'd0, op}};
    endcase
    return r;
  endfunction

  logic [63:0] alu_res;
  assign alu_res   = alu_model(alu_operation[31:27], alu_a, alu_b, alu_flag);
  assign alu_zlow  = alu_res[31:0];
  assign alu_zhigh = alu_res[63:32];

  function automatic exp_t predict(input logic [4:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic flag);
    exp_t e;
    logic [63:0] r;
    int unsigned opv;
    opv = op;
    e.lo = 32'd0; e.hi = 32'd0; e.wide = 1'b0; e.ill = 1'b0; e.dz = 1'b0;
    e.lat = 0; e.acc = 0;
    if (!(opv <= 12 || (opv >= 15 && opv <= 19))) begin
      e.ill = 1'b1;
      e.lat = 1;
    end else if (opv == 16 && b == 32'd0) begin
      e.dz = 1'b1;
      e.wide = 1'b1;
      e.lat = 1;
    end else begin
      r = alu_model(op, a, b, flag);
      e.wide = (opv == 15 || opv == 16);
      e.lo = r[31:0];
      e.hi = e.wide ? r[63:32] : 32'd0;
      e.lat = 2 + ((opv == 15) ? MUL_W : (opv == 16) ? DIV_W : 0);
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Issue one request and queue its expected response at the accept point.
  task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic flag);
    int waited;
    exp_t e;
    waited = 0;
    @(negedge clock);
    req_ir = {op, 27'($urandom)};
    req_a = a;
    req_b = b;
    req_flag = flag;
    req_valid = 1'b1;
    while (!req_ready && waited < 200) begin
      @(negedge clock);
      waited++;
    end
    chk("accept_ready", req_ready, 1);
    if (req_ready) begin
      e = predict(op, a, b, flag);
      e.acc = cyc + 1;
      expq.push_back(e);
      @(negedge clock);
    end
    // Scramble request inputs after the accept edge; they must be ignored.
    req_valid = 1'b0;
    req_ir = $urandom;
    req_a = $urandom;
    req_b = $urandom;
    req_flag = 1'($urandom);
  endtask

  task automatic wait_idle();
    int waited;
    waited = 0;
    @(negedge clock);
    while (!(req_ready && expq.size() == 0 && !have_cur) && waited < 200) begin
      @(negedge clock);
      waited++;
    end
    chk("idle_reached", req_ready && expq.size() == 0 && !have_cur, 1);
  endtask

  // Response consumer: random ready, with optional forced stall.
  always @(posedge clock) begin
    #1;
    if (rsp_valid && hold_cnt > 0) begin
      rsp_ready = 1'b0;
      hold_cnt--;
    end else begin
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: compares presented responses against the scoreboard.
  always @(negedge clock) begin
    if (!clear) begin
      expq.delete();
      have_cur = 1'b0;
    end else if (rsp_valid) begin
      chk("req_ready_low_in_resp", req_ready, 0);
      chk("alu_zero_in_resp", {alu_operation, alu_a, alu_b, alu_flag} == 97'd0, 1);
      if (!have_cur) begin
        chk("rsp_has_pending_request", expq.size() != 0, 1);
        if (expq.size() != 0) begin
          cur = expq.pop_front();
          have_cur = 1'b1;
          chk("rsp_lo", rsp_lo, cur.lo);
          chk("rsp_hi", rsp_hi, cur.hi);
          chk("rsp_flags", {rsp_wide, rsp_illegal, rsp_divzero}, {cur.wide, cur.ill, cur.dz});
          chk("latency", cyc - cur.acc, cur.lat);
        end
      end else begin
        chk("stable_rsp", {rsp_lo, rsp_hi, rsp_wide, rsp_illegal, rsp_divzero},
            {cur.lo, cur.hi, cur.wide, cur.ill, cur.dz});
      end
      if (rsp_ready) have_cur = 1'b0;
    end
  end

  initial begin
    logic [4:0]  op;
    logic [31:0] b;

    // Reset state.
    #2 clear = 1'b0;
    #1;
    chk("reset_outputs",
        {rsp_valid, rsp_wide, rsp_illegal, rsp_divzero, |rsp_lo, |rsp_hi,
         |alu_operation, |alu_a, |alu_b, alu_flag}, 0);
    repeat (2) @(negedge clock);
    clear = 1'b1;
    #1;
    chk("req_ready_after_reset", req_ready, 1);

    // ADD 5 + 7.
    send(5'b00011, 32'd5, 32'd7, 1'b0);
    wait_idle();
    // MUL 0x10000 * 0x10000 -> hi=1, lo=0.
    send(5'b01111, 32'h10000, 32'h10000, 1'b0);
    wait_idle();
    // DIV by zero, then 17 / 5.
    send(5'b10000, 32'd9, 32'd0, 1'b0);
    wait_idle();
    send(5'b10000, 32'd17, 32'd5, 1'b0);
    wait_idle();
    // Illegal opcode with the response stalled for three cycles.
    hold_cnt = 3;
    send(5'b11111, 32'd1, 32'd2, 1'b0);
    wait_idle();
    // Branch with both flag values.
    send(5'b10011, 32'd100, 32'd20, 1'b1);
    send(5'b10011, 32'd100, 32'd20, 1'b0);
    wait_idle();

    // Reset in the middle of a divide's EXEC phase.
    send(5'b10000, 32'd1000, 32'd7, 1'b0);
    @(negedge clock);
    #2 clear = 1'b0;
    #1;
    chk("midop_reset_outputs",
        {rsp_valid, rsp_wide, rsp_illegal, rsp_divzero, |rsp_lo, |rsp_hi,
         |alu_operation, |alu_a, |alu_b, alu_flag}, 0);
    repeat (2) @(negedge clock);
    clear = 1'b1;
    #1;
    chk("req_ready_after_midop_reset", req_ready, 1);
    repeat (10) @(negedge clock);
    send(5'b00011, 32'hFFFF_FFFF, 32'd2, 1'b0);
    wait_idle();

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      op = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) op = 5'b10000;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      send(op, $urandom, b, 1'($urandom));
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 4)) @(negedge clock);
    end
    wait_idle();
    chk("scoreboard_empty", expq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_alu_op_sequencer

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 The block SHALL have parameter MUL_WAIT, default 2, meaning extra EXEC cycles held for multiply (opcode 01111).
REQ-002 The block SHALL have parameter DIV_WAIT, default 4, meaning extra EXEC cycles held for divide (opcode 10000).
REQ-003 The block SHALL have port clock, input, 1, the single rising-edge clock.
REQ-004 The block SHALL have port clear, input, 1, the asynchronous active-low reset.
REQ-005 The block SHALL have ports req_valid (input, 1, request present) and req_ready (output, 1, request accepted when both are high).
REQ-006 The block SHALL have ports req_ir (input, 32, instruction with opcode in [31:27]), req_a (input, 32, operand A) and req_b (input, 32, operand B).
REQ-007 The block SHALL have port req_flag, input, 1, the branch condition for opcode 10011.
REQ-008 The block SHALL have ports alu_operation (output, 32), alu_a (output, 32), alu_b (output, 32) and alu_flag (output, 1), all driving the ALU.
REQ-009 The block SHALL have ports alu_zlow (input, 32) and alu_zhigh (input, 32), the ALU results.
REQ-010 The block SHALL have ports rsp_valid (output, 1), rsp_ready (input, 1), rsp_lo (output, 32), rsp_hi (output, 32), rsp_wide (output, 1, hi word meaningful), rsp_illegal (output, 1) and rsp_divzero (output, 1).

Function
REQ-011 States: IDLE, LOAD, EXEC, RESP, encoded as 2-bit state.
- req_ready = 1 only in IDLE.
REQ-012 Accept transition: IDLE -> LOAD on req_valid & req_ready.
- Latches req_ir, req_a, req_b and req_flag into internal registers.
REQ-013 LOAD -> EXEC after exactly 1 cycle.
- Latched values drive alu_* from LOAD through EXEC.
- alu_* outputs = 0 in IDLE and RESP.
REQ-014 Legal opcodes: 00000-00110, 00111-01100, 01111, 10000, 10001, 10010, 10011.
- Illegal opcode: LOAD -> RESP with rsp_illegal=1, rsp_lo=rsp_hi=0, EXEC skipped.
REQ-015 EXEC duration: 1 cycle, plus MUL_WAIT cycles for 01111 or DIV_WAIT cycles for 10000.
- Counted by a down-counter loaded on LOAD -> EXEC.
REQ-016 EXEC -> RESP when the counter reaches 0.
- Captures rsp_lo=alu_zlow on that edge.
- Captures rsp_hi=alu_zhigh and rsp_wide=1 only for 01111 or 10000; otherwise rsp_hi=0 and rsp_wide=0.
REQ-017 Divide with B=0: EXEC is skipped (no wait), RESP entered with rsp_divzero=1, rsp_lo=rsp_hi=0 and rsp_wide=1.
REQ-018 Response handshake:
- rsp_valid = 1 only in RESP.
- rsp_* outputs hold stable until rsp_ready.
- RESP -> IDLE on rsp_ready.
- The next request cannot be accepted in the same cycle (req_ready is low in RESP).
REQ-019 Latency, accept edge to rsp_valid high: 2 cycles for simple ops, 2+MUL_WAIT for multiply, 2+DIV_WAIT for divide, 1 for illegal or divide-by-zero.
REQ-020 req_* input changes outside the accept edge SHALL have no effect.

Reset
REQ-021 clear low SHALL immediately force:
- state IDLE, counter 0;
- rsp_valid, rsp_wide, rsp_illegal, rsp_divzero = 0;
- rsp_lo, rsp_hi, alu_* = 0;
- req_ready = 1 once clear is high.
REQ-022 Reset mid-operation SHALL discard the in-flight request with no response; first accept is possible on the first rising edge after clear deasserts.

Structure
REQ-023 Opcode localparams (OP_ADD=00011, OP_SUB=00100, OP_MUL=01111, OP_DIV=10000, OP_BRANCH=10011, etc.) and the state encoding SHALL live in a shared package also used by the ALU.
REQ-024 A legality/wait-count decoder sub-module, op_decode, SHALL be used: input opcode; outputs legal, is_wide, wait_cycles.

Verification
REQ-025 ADD: req_a=5, req_b=7, ir[31:27]=00011 -> rsp_valid 2 cycles after accept, rsp_lo=12, rsp_wide=0.
REQ-026 MUL with default MUL_WAIT: A=0x10000, B=0x10000 -> rsp_valid after 4 cycles, rsp_lo=0, rsp_hi=1, rsp_wide=1.
REQ-027 DIV by zero: A=9, B=0 -> rsp_valid after 1 cycle, rsp_divzero=1, rsp_lo=0; then DIV 17/5 -> rsp_lo=3, rsp_hi=2 after 6 cycles.
REQ-028 Illegal opcode 11111 -> rsp_illegal=1 after 1 cycle; rsp_ready held low 3 cycles -> rsp_* stable and req_ready stays 0.
REQ-029 clear pulsed low during EXEC of a DIV -> all outputs 0 immediately, no rsp_valid afterwards, next ADD completes normally.
